elastic_pipe_reg: RTL

Parametrised inter-stage pipeline register: the next generation of the per-stage latches bundled in the pipeline register interface. It carries a DATA_W-bit payload with a valid/ready handshake instead of a global enable, and offers an optional two-entry skid buffer so upstream ready stays registered. Flush clears the stage to a NOP bubble, and saturating counters report stall and flush activity. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with DATA_W set to that stage's packed bundle width.

---
 rtl/cpu_types_pkg.sv | 54 +++++
 rtl/sat_counter.sv | 26 ++
 rtl/elastic_pipe_reg.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline register state, common word types and the
// packed stage bundles carried by elastic_pipe_reg at each stage boundary.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } pipe_state_t;

  // Replicated to DATA_W bits wherever a stage is cleared to a bubble.
  localparam logic PIPE_NOP = 1'b0;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } if_id_t;

  typedef struct packed {
    word_t    pc;
    word_t    rdat1;
    word_t    rdat2;
    word_t    imm;
    regbits_t rd;
    logic     regWen;
  } id_ex_t;

  typedef struct packed {
    word_t    aluOut;
    word_t    storeData;
    regbits_t rd;
    logic     memRen;
    logic     memWen;
    logic     regWen;
  } ex_mem_t;

  typedef struct packed {
    word_t    wdat;
    regbits_t rd;
    logic     regWen;
  } mem_wb_t;

  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    case (s)
      FULL:    state_occupancy = 2'd1;
      SKIDDED: state_occupancy = 2'd2;
      default: state_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Valid/ready inter-stage pipeline register with optional two-entry skid
// buffer, flush-to-bubble and saturating stall/flush activity counters.
module elastic_pipe_reg
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        occupancy
);

  pipe_state_t       r_state;
  pipe_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_main_q;
  logic [DATA_W-1:0] r_skid_q;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_stall_inc;
  logic              w_flush_inc;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= EMPTY;
      r_main_q <= '0;
      r_skid_q <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_main_q <= w_main_nxt;
      r_skid_q <= w_skid_nxt;
    end
  end

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Storage is zeroed on every transition into EMPTY so out_data reads as a NOP.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main_q;
    w_skid_nxt  = r_skid_q;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = {DATA_W{PIPE_NOP}};
      w_skid_nxt  = {DATA_W{PIPE_NOP}};
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = FULL;
            w_main_nxt  = in_data;
          end
        end
        FULL: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = in_data;
          end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = {DATA_W{PIPE_NOP}};
          end else if (w_in_xfer) begin
            w_state_nxt = SKIDDED;
            w_skid_nxt  = in_data;
          end
        end
        SKIDDED: begin
          if (w_out_xfer) begin
            w_state_nxt = FULL;
            w_main_nxt  = r_skid_q;
            w_skid_nxt  = {DATA_W{PIPE_NOP}};
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_nxt  = {DATA_W{PIPE_NOP}};
          w_skid_nxt  = {DATA_W{PIPE_NOP}};
        end
      endcase
    end
  end

  // With the skid buffer, in_ready comes from registered state only.
  always_comb begin
    out_valid = (r_state != EMPTY);
    out_data  = r_main_q;
    occupancy = state_occupancy(r_state);
    if (SKID) begin
      in_ready = (r_state != SKIDDED);
    end else begin
      in_ready = (r_state == EMPTY) | out_ready;
    end
  end

  assign w_stall_inc = out_valid & ~out_ready & ~flush;
  assign w_flush_inc = flush & out_valid;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (cnt_clr),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (cnt_clr),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

endmodule
